// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider. It produces one quotient bit per clock and
//   uses a start/done handshake. It sits beside the multiplier cells in the
//   arithmetic unit.
//
//   Parameter
//     WIDTH        operand/result width, 2..32 (default 4)
//
//   Ports
//     clk          system clock, rising edge
//     rst          synchronous, active-high reset
//     start        divide request, sampled only when not busy
//     dividend     numerator, captured on the accepting edge
//     divisor      denominator, captured on the accepting edge
//     busy         high while iterating
//     done         one-cycle pulse when results are valid
//     quotient     registered result, held until the next completion
//     remainder    registered result, held until the next completion
//     div_by_zero  set together with done when the captured divisor was 0
//
//   Optional feature (macro SEQ_DIVIDER_SIGNED_EN)
//     When this macro is defined, operands and results are two's complement.
//     Magnitudes go through the same unsigned core. The sign fix-up happens on
//     the completing edge, so latency does not change.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | iterating, one quotient bit per clock
//   DONE   | single cycle, results valid, start accepted back-to-back
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RW-1:0]    r_rem;
  logic [WIDTH-1:0] r_quo_sr;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [RW-1:0]    w_shift;
  logic             w_ge;
  logic [RW-1:0]    w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_low;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  assign w_accept   = start && (r_state != S_RUN);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_state == S_RUN) && (r_count == LAST);

  // The partial remainder stays below the divisor, so the bit that leaves
  // the top of the WIDTH+1 window on the shift is always zero.
  assign w_shift   = RW'({r_rem, r_quo_sr[WIDTH-1]});
  assign w_ge      = (w_shift >= {1'b0, r_divisor});
  assign w_rem_nxt = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
  assign w_quo_nxt = {r_quo_sr[WIDTH-2:0], w_ge};
  assign w_rem_low = WIDTH'(w_rem_nxt);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_dvd_neg;
  logic r_dvs_neg;

  assign w_dvd_neg = dividend[WIDTH-1];
  assign w_dvs_neg = divisor[WIDTH-1];
  // The magnitude of the most-negative value is still correct when it is
  // read as unsigned, so no extra bit is needed.
  assign w_dvd_mag = w_dvd_neg ? (-dividend) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (-divisor) : divisor;

  // Truncation toward zero: the quotient sign follows the operand signs and
  // the remainder sign follows the dividend.
  assign w_q_final = (r_dvd_neg ^ r_dvs_neg) ? (-w_quo_nxt) : w_quo_nxt;
  assign w_r_final = r_dvd_neg ? (-w_rem_low) : w_rem_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
    end else if (w_accept) begin
      r_dvd_neg <= w_dvd_neg;
      r_dvs_neg <= w_dvs_neg;
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_final = w_quo_nxt;
  assign w_r_final = w_rem_low;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_count == LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = w_dvs_zero ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo_sr    <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_rem     <= '0;
      r_quo_sr  <= w_dvd_mag;
      r_divisor <= w_dvs_mag;
      r_count   <= '0;
      if (w_dvs_zero) begin
        // No iteration is needed for a zero divisor, so the result is loaded
        // right away.
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_rem    <= w_rem_nxt;
      r_quo_sr <= w_quo_nxt;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        quotient    <= w_q_final;
        remainder   <= w_r_final;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa;
      int sd;
      sa = $signed(a);
      sd = $signed(b);
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
`else
      int ua;
      int ud;
      ua = int'(a);
      ud = int'(b);
      e.q = W'(ua / ud);
      e.r = W'(ua % ud);
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
  endtask

  // Entered at the negedge that is n0 samples after the accepting edge.
  task automatic wait_done(input int n0, input int exp_lat, input string tag);
    int           n;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic         hz;
    bit           held;
    bit           busy_ok;
    exp_t         e;
    n       = n0;
    hq      = quotient;
    hr      = remainder;
    hz      = div_by_zero;
    held    = 1'b1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 64) begin
      if (quotient !== hq || remainder !== hr || div_by_zero !== hz) held = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, " done seen"}, done, 1'b1);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " busy low at done"}, busy, 1'b0);
    chk({tag, " busy while running"}, busy_ok, 1'b1);
    chk({tag, " outputs held"}, held, 1'b1);
    chk({tag, " scoreboard has entry"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " quotient"}, quotient, e.q);
      chk({tag, " remainder"}, remainder, e.r);
      chk({tag, " div_by_zero"}, div_by_zero, e.dbz);
    end
  endtask

  task automatic no_done(input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 13/3
    issue(4'd13, 4'd3);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "13/3");
    @(negedge clk);
    chk("13/3 done single cycle", done, 1'b0);

    // 7/0: done right after acceptance, busy never high
    issue(4'd7, 4'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 1, "7/0");
    @(negedge clk);
    chk("7/0 done single cycle", done, 1'b0);

    // 15/1 then 2/5, second start presented during the first done
    issue(4'd15, 4'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "15/1");
    issue(4'd2, 4'd5);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "2/5 back-to-back");

    // start during RUN is ignored
    @(negedge clk);
    issue(4'd14, 4'd3);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, LAT, "14/3 with ignored start");
    no_done(10, "no second done after ignored start");

    // reset mid-operation
    dividend = 4'd11;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 1'b0);
    no_done(8, "no done after abort");
    issue(4'd11, 4'd2);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "11/2 after abort");

    // sign-sensitive operands (-7/2 and -8/-1 in the signed build)
    @(negedge clk);
    issue(4'h9, 4'd2);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "9h/2");
    issue(4'h8, 4'hF);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, LAT, "8h/Fh");

    // random operations, zero divisors included
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      if (k % 5 == 0) b = '0;
      @(negedge clk);
      issue(a, b);
      @(negedge clk);
      start = 1'b0;
      wait_done(1, (b == '0) ? 1 : LAT, "random");
    end

    @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
